wb_stream_writer_cfg_mc: RTL

Multi-channel Wishbone slave configuration and status block for the stream writer DMA engines. It holds per-channel start address, buffer size and burst size, and issues per-channel start pulses. It tracks per-channel busy/done state and raises a maskable interrupt. It sits between the CPU-side Wishbone bus and `CHANNELS` stream writer instances, and extends the single-channel write-only configuration block with readback, status and error responses.

---
 rtl/wb_stream_writer_cfg_mc_if.sv | 28 ++
 rtl/wb_stream_writer_cfg_mc.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/wb_stream_writer_cfg_mc_if.sv
// Wishbone classic bus bundle between the CPU side and the stream writer config block.
interface wb_stream_writer_cfg_mc_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] wb_adr_i;
    logic [DW-1:0] wb_dat_i;
    logic [3:0]    wb_sel_i;
    logic          wb_we_i;
    logic          wb_cyc_i;
    logic          wb_stb_i;
    logic [2:0]    wb_cti_i;
    logic [1:0]    wb_bte_i;
    logic [DW-1:0] wb_dat_o;
    logic          wb_ack_o;
    logic          wb_err_o;
    logic          wb_rty_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );
endinterface

// File: rtl/wb_stream_writer_cfg_mc.sv
// Multi-channel Wishbone config/status block for the stream writer DMA engines.
// Optional interrupt logic is enabled by defining WB_STREAM_WRITER_CFG_IRQ_EN.
module wb_stream_writer_cfg_mc #(
    parameter int WB_AW    = 32,
    parameter int WB_DW    = 32,
    parameter int CHANNELS = 2
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    wb_stream_writer_cfg_mc_if.slave  wb,
    output logic [CHANNELS-1:0]       enable,
    output logic [CHANNELS*WB_AW-1:0] start_adr,
    output logic [CHANNELS*WB_AW-1:0] buf_size,
    output logic [CHANNELS*WB_AW-1:0] burst_size,
    input  logic [CHANNELS-1:0]       done_i,
    output logic [CHANNELS-1:0]       busy_o,
    output logic                      irq_o
);
    localparam int             LP_WW    = WB_AW - 2;
    localparam logic [LP_WW-1:0] LP_LIMIT = LP_WW'(4 * (CHANNELS + 1));

    logic [LP_WW-1:0]    w_word;
    logic                w_req;
    logic                w_wr;
    logic                w_is_glb;
    logic                w_mapped;
    logic [WB_DW-1:0]    w_wmask;
    logic [WB_DW-1:0]    w_wdat_m;
    logic [CHANNELS-1:0] w_wbits;
    logic [CHANNELS-1:0] w_ch_hit;
    logic [CHANNELS-1:0] w_cfg_ok;
    logic [CHANNELS-1:0] w_start;
    logic [CHANNELS-1:0] w_done;
    logic [CHANNELS-1:0] w_irq_status;
    logic [CHANNELS-1:0] w_irq_mask;
    logic [WB_DW-1:0]    w_rd_ch [CHANNELS];
    logic [WB_DW-1:0]    w_rd;
    logic                w_unused;

    logic [CHANNELS-1:0] r_enable;
    logic [CHANNELS-1:0] r_busy;
    logic [WB_DW-1:0]    r_dat;
    logic                r_ack;
    logic                r_err;

    function automatic logic [WB_AW-1:0] f_merge(input logic [WB_AW-1:0] old_v,
                                                 input logic [WB_DW-1:0] dat_v,
                                                 input logic [WB_DW-1:0] msk_v);
        return WB_AW'((WB_DW'(old_v) & ~msk_v) | (dat_v & msk_v));
    endfunction

    assign w_word   = wb.wb_adr_i[WB_AW-1:2];
    assign w_req    = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack & ~r_err;
    assign w_wr     = w_req & wb.wb_we_i;
    assign w_is_glb = (w_word[LP_WW-1:2] == '0);
    // Slot k3 of every channel window is reserved and answers with err.
    assign w_mapped = w_is_glb | ((w_word < LP_LIMIT) & (w_word[1:0] != 2'd3));
    assign w_wmask  = WB_DW'({{8{wb.wb_sel_i[3]}}, {8{wb.wb_sel_i[2]}},
                              {8{wb.wb_sel_i[1]}}, {8{wb.wb_sel_i[0]}}});
    assign w_wdat_m = wb.wb_dat_i & w_wmask;
    assign w_wbits  = w_wdat_m[CHANNELS-1:0];
    assign w_unused = ^{wb.wb_cti_i, wb.wb_bte_i, wb.wb_adr_i[1:0]};

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [WB_AW-1:0] r_start_adr;
            logic [WB_AW-1:0] r_buf_size;
            logic [WB_AW-1:0] r_burst_size;
            logic             w_cfg_we;

            assign w_ch_hit[gi] = (w_word[LP_WW-1:2] == (LP_WW-2)'(gi + 1));
            assign w_cfg_we     = w_wr & w_ch_hit[gi] & ~r_busy[gi];

            always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
                if (!wb_rst_i) begin
                    r_start_adr  <= '0;
                    r_buf_size   <= '0;
                    r_burst_size <= '0;
                end else if (w_cfg_we) begin
                    case (w_word[1:0])
                        2'd0:    r_start_adr  <= f_merge(r_start_adr, wb.wb_dat_i, w_wmask);
                        2'd1:    r_buf_size   <= f_merge(r_buf_size, wb.wb_dat_i, w_wmask);
                        2'd2:    r_burst_size <= f_merge(r_burst_size, wb.wb_dat_i, w_wmask);
                        default: ;
                    endcase
                end
            end

            assign start_adr [gi*WB_AW +: WB_AW] = r_start_adr;
            assign buf_size  [gi*WB_AW +: WB_AW] = r_buf_size;
            assign burst_size[gi*WB_AW +: WB_AW] = r_burst_size;
            assign w_cfg_ok[gi] = (|r_buf_size) & (|r_burst_size);
            assign w_rd_ch[gi]  = (w_word[1:0] == 2'd0) ? WB_DW'(r_start_adr)  :
                                  (w_word[1:0] == 2'd1) ? WB_DW'(r_buf_size)   :
                                  (w_word[1:0] == 2'd2) ? WB_DW'(r_burst_size) : '0;
        end
    endgenerate

    // Start decision looks at pre-edge busy, so a start racing a done is dropped.
    assign w_start = {CHANNELS{w_wr & (w_word == '0)}} & w_wbits & ~r_busy & w_cfg_ok;
    assign w_done  = done_i & r_busy;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_enable <= '0;
            r_busy   <= '0;
        end else begin
            r_enable <= w_start;
            r_busy   <= (r_busy & ~w_done) | w_start;
        end
    end

`ifdef WB_STREAM_WRITER_CFG_IRQ_EN
    logic [CHANNELS-1:0] r_irq_status;
    logic [CHANNELS-1:0] r_irq_mask;
    logic                r_irq;
    logic [CHANNELS-1:0] w_w1c;

    assign w_w1c = (w_wr && w_word == LP_WW'(1)) ? w_wbits : '0;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_irq_status <= '0;
            r_irq_mask   <= '0;
            r_irq        <= 1'b0;
        end else begin
            // Completion set wins over a concurrent write-1-to-clear.
            r_irq_status <= (r_irq_status & ~w_w1c) | w_done;
            if (w_wr && w_word == LP_WW'(2))
                r_irq_mask <= (r_irq_mask & ~w_wmask[CHANNELS-1:0]) | w_wbits;
            r_irq <= |(r_irq_status & r_irq_mask);
        end
    end

    assign w_irq_status = r_irq_status;
    assign w_irq_mask   = r_irq_mask;
    assign irq_o        = r_irq;
`else
    assign w_irq_status = '0;
    assign w_irq_mask   = '0;
    assign irq_o        = 1'b0;
`endif

    always_comb begin
        w_rd = '0;
        if (w_is_glb) begin
            case (w_word[1:0])
                2'd0:    w_rd[CHANNELS-1:0] = r_busy;
                2'd1:    w_rd[CHANNELS-1:0] = w_irq_status;
                2'd2:    w_rd[CHANNELS-1:0] = w_irq_mask;
                default: w_rd = WB_DW'({16'h0001, 8'h00, 8'(CHANNELS)});
            endcase
        end else begin
            for (int c = 0; c < CHANNELS; c++)
                if (w_ch_hit[c]) w_rd = w_rd_ch[c];
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_req & w_mapped;
            r_err <= w_req & ~w_mapped;
            if (w_req) r_dat <= w_mapped ? w_rd : '0;
        end
    end

    assign wb.wb_dat_o = r_dat;
    assign wb.wb_ack_o = r_ack;
    assign wb.wb_err_o = r_err;
    assign wb.wb_rty_o = 1'b0;
    assign enable      = r_enable;
    assign busy_o      = r_busy;
endmodule
